// File: rtl/text_loader_mem.sv
// ============================================================================
// Module      : text_loader_mem
// Description : Instruction-text memory for the IF stage with a byte-stream
//               loader. Narrow beats are packed little-endian into words and
//               written from a programmable base address; fetch reads through
//               an independent registered read port.
//               Optional checksum: define TEXT_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_loader_mem #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int IN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   load_words,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int LANES  = DATA_W / IN_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   waddr;
  logic [LANE_W-1:0]   lane;
  logic [DATA_W-1:0]   assembly;
  logic                end_flag;

  logic                accept;
  logic                word_complete;
  logic                do_write;
  logic                drop_word;
  logic [DATA_W-1:0]   word_next;

  logic [DATA_W-1:0]   mem [DEPTH];

  // A restart pulse wins over a beat presented in the same cycle, and reset
  // (active low) blocks any write so memory is never disturbed by it.
  assign accept        = rst & ~load_start & (state == LOAD) & in_ready & in_valid;
  assign word_complete = (lane == LANE_W'(LANES - 1)) | in_last;
  assign do_write      = accept & word_complete & ~end_flag;
  assign drop_word     = accept & word_complete & end_flag;

  // The current beat lands in lane 'lane'; other lanes keep the assembly
  // register, which is zero above the fill point, giving zero padding.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign word_next[g*IN_W +: IN_W] =
        (lane == LANE_W'(g)) ? in_data : assembly[g*IN_W +: IN_W];
    end
  endgenerate

  // Loader control: state, handshake, word assembly and status counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      load_words <= '0;
      waddr      <= '0;
      lane       <= '0;
      assembly   <= '0;
      end_flag   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state      <= LOAD;
        in_ready   <= 1'b1;
        load_busy  <= 1'b1;
        overflow   <= 1'b0;
        load_words <= '0;
        waddr      <= load_base;
        lane       <= '0;
        assembly   <= '0;
        end_flag   <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (word_complete) begin
                lane     <= '0;
                assembly <= '0;
                if (do_write) begin
                  load_words <= load_words + 1'b1;
                  // The last address is written once; further words are
                  // dropped rather than wrapping onto the start of memory.
                  if (waddr == '1) begin
                    end_flag <= 1'b1;
                  end else begin
                    waddr <= waddr + 1'b1;
                  end
                end
                if (drop_word) begin
                  overflow <= 1'b1;
                end
              end else begin
                lane     <= lane + 1'b1;
                assembly <= word_next;
              end
              if (in_last) begin
                state     <= DONE;
                in_ready  <= 1'b0;
                load_busy <= 1'b0;
                load_done <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TEXT_LOADER_CHECKSUM_EN
  // Modular sum of every word actually committed to memory during this load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum <= '0;
    end else if (load_start) begin
      checksum <= '0;
    end else if (do_write) begin
      checksum <= checksum + word_next;
    end
  end
`else
  assign checksum = '0;
`endif

  // Write port of the text array; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[waddr] <= word_next;
    end
  end

  // Registered fetch port; a same-cycle write to raddr returns the old word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_loader_mem.sv
// ============================================================================
// Module      : tb_text_loader_mem
// Description : Directed self-checking bench for text_loader_mem
//               (ADDR_W=4, DATA_W=32, IN_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_loader_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [3:0]  load_base;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        load_busy;
  logic        load_done;
  logic        overflow;
  logic [4:0]  load_words;
  logic [31:0] checksum;
  logic [3:0]  raddr;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  text_loader_mem #(.ADDR_W(4), .DATA_W(32), .IN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .overflow   (overflow),
    .load_words (load_words),
    .checksum   (checksum),
    .raddr      (raddr),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  // Expected checksum depends on whether the accumulator is built.
  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef TEXT_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  // All drive/sample activity happens on falling edges.
  task automatic start_load(input logic [3:0] base);
    load_start = 1'b1;
    load_base  = base;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    raddr = a;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_data = 8'hFF;
    load_start = 1'b0; load_base = '0; raddr = '0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (load_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", load_busy); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", load_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (load_words !== 5'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", load_words); end
    total++; if (checksum !== 32'h0) begin bad++; $display("FAIL reset_checksum got=%h want=0", checksum); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_word();
    logic [7:0]  img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [31:0] d;
    start_load(4'd0);
    total++; if (in_ready !== 1'b1 || load_busy !== 1'b1) begin bad++; $display("FAIL two_ready_after_start got=%b%b want=11", in_ready, load_busy); end
    for (int i = 0; i < 8; i++) beat(img[i], i == 7);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL two_done got=%b want=1", load_done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL two_ready_fall got=%b want=0", in_ready); end
    total++; if (load_words !== 5'd2) begin bad++; $display("FAIL two_words got=%0d want=2", load_words); end
    total++; if (checksum !== exp_sum(32'h001000A6)) begin bad++; $display("FAIL two_checksum got=%h want=%h", checksum, exp_sum(32'h001000A6)); end
    @(negedge clk);
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL two_done_pulse got=%b want=0", load_done); end
    rd(4'd0, d);
    total++; if (d !== 32'h00000013) begin bad++; $display("FAIL two_mem0 got=%h want=00000013", d); end
    rd(4'd1, d);
    total++; if (d !== 32'h00100093) begin bad++; $display("FAIL two_mem1 got=%h want=00100093", d); end
  endtask

  task automatic test_partial_gaps();
    logic [31:0] old6, d;
    rd(4'd6, old6);
    start_load(4'd5);
    beat(8'hAA, 1'b0);
    @(negedge clk);
    beat(8'hBB, 1'b0);
    @(negedge clk);
    @(negedge clk);
    beat(8'hCC, 1'b1);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL part_done got=%b want=1", load_done); end
    total++; if (load_words !== 5'd1) begin bad++; $display("FAIL part_words got=%0d want=1", load_words); end
    total++; if (checksum !== exp_sum(32'h00CCBBAA)) begin bad++; $display("FAIL part_checksum got=%h want=%h", checksum, exp_sum(32'h00CCBBAA)); end
    rd(4'd5, d);
    total++; if (d !== 32'h00CCBBAA) begin bad++; $display("FAIL part_mem5 got=%h want=00CCBBAA", d); end
    rd(4'd6, d);
    total++; if (d !== old6) begin bad++; $display("FAIL part_mem6 got=%h want=%h", d, old6); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int          acc = 0;
    start_load(4'd15);
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b1) acc++;
      beat(8'(i + 1), i == 7);
    end
    total++; if (acc !== 8) begin bad++; $display("FAIL ovf_accepted got=%0d want=8", acc); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (load_words !== 5'd1) begin bad++; $display("FAIL ovf_words got=%0d want=1", load_words); end
    total++; if (checksum !== exp_sum(32'h04030201)) begin bad++; $display("FAIL ovf_checksum got=%h want=%h", checksum, exp_sum(32'h04030201)); end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b want=1", load_done); end
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    rd(4'd15, d);
    total++; if (d !== 32'h04030201) begin bad++; $display("FAIL ovf_mem15 got=%h want=04030201", d); end
    rd(4'd0, d);
    total++; if (d !== 32'h00000013) begin bad++; $display("FAIL ovf_no_wrap got=%h want=00000013", d); end
  endtask

  task automatic test_restart_idle();
    logic [31:0] old3, d;
    rd(4'd3, old3);
    // Beats while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hEE; in_valid = 1'b1; in_last = (i == 1);
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin bad++; $display("FAIL idle_beat got=%b%b%b want=000", in_ready, load_busy, load_done); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    start_load(4'd0);
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    start_load(4'd3);
    total++; if (load_words !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL restart_clear got=%0d/%b want=0/0", load_words, overflow); end
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    raddr = 4'd3;
    beat(8'h44, 1'b1);
    // Read of the address written on the same edge returns the old word.
    total++; if (rdata !== old3) begin bad++; $display("FAIL collide_old got=%h want=%h", rdata, old3); end
    total++; if (load_words !== 5'd1) begin bad++; $display("FAIL restart_words got=%0d want=1", load_words); end
    total++; if (checksum !== exp_sum(32'h44332211)) begin bad++; $display("FAIL restart_checksum got=%h want=%h", checksum, exp_sum(32'h44332211)); end
    @(negedge clk);
    total++; if (rdata !== 32'h44332211) begin bad++; $display("FAIL collide_new got=%h want=44332211", rdata); end
    rd(4'd0, d);
    total++; if (d !== 32'h00000013) begin bad++; $display("FAIL restart_mem0 got=%h want=00000013", d); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_partial_gaps();
    test_overflow();
    test_restart_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
